// File: rtl/btn_mode_sel.sv
// btn_mode_sel: turns debounced-driver press pulses into a registered mode
// selection. A single press advances the mode (wrapping), a second press
// inside the double-press window returns it to 0, and a lockout period after
// every accepted press swallows bounce pulses.
module btn_mode_sel #(
  parameter int unsigned N_MODES  = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned LOCK_CYC = 16,
  parameter int unsigned DBL_CYC  = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pulse_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             chg_o,
  output logic             dbl_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(DBL_CYC);

  localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(N_MODES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_WIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             arm_q,   arm_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic             chg_q,   chg_d;
  logic             dbl_q,   dbl_d;

  // State and output registers; reset abandons any pending window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
      sel_q   <= '0;
      chg_q   <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      sel_q   <= sel_d;
      chg_q   <= chg_d;
      dbl_q   <= dbl_d;
    end
  end

  // Press classification, lockout/window timing and next mode selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arm_d   = arm_q;
    sel_d   = sel_q;
    chg_d   = 1'b0;
    dbl_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pulse_i) begin
          sel_d   = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
          chg_d   = 1'b1;
          cnt_d   = '0;
          arm_d   = 1'b1;
          state_d = S_LOCK;
        end
      end

      S_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LOCK_LAST) begin
          state_d = arm_q ? S_WIN : S_IDLE;
        end
      end

      S_WIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A press on the expiry cycle still counts as a double press.
        if (pulse_i) begin
          sel_d   = '0;
          chg_d   = 1'b1;
          dbl_d   = 1'b1;
          cnt_d   = '0;
          arm_d   = 1'b0;
          state_d = S_LOCK;
        end else if (cnt_q == DBL_LAST) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered except busy_o, a direct decode of the state.
  always_comb begin
    sel_o  = sel_q;
    chg_o  = chg_q;
    dbl_o  = dbl_q;
    busy_o = (state_q == S_LOCK);
  end

endmodule
